// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Sequences RV32I instructions through INIT/FETCH/DECODE/EXECUTE/MEM/WB,
//   gating write and branch strobes by state. Static datapath controls are a
//   combinational decode of op/funct3/funct7. Also flags illegal opcodes,
//   aborts stalled memory accesses after MEM_TIMEOUT cycles and counts
//   retired instructions.
// Parameters:
//   MEM_HANDSHAKE  1: MEM waits for dmem_ready, 0: MEM lasts one cycle
//   MEM_TIMEOUT    max MEM cycles without dmem_ready before abort (>=2)
//   CNT_W          width of the retired-instruction counter
// Ports:
//   clk, reset (async, active-low)
//   op/funct3/funct7       instruction fields from the instruction register
//   dmem_ready             data memory completes access this cycle
//   ir_en, pc_en           IR load / PC update strobes
//   regFile_wr_en, dataMem_wr_en, dataMem_rd_req   write / request strobes
//   AluSrcMuxSel, RFWriteDataSrcMuxSel, immExtType, dataMemWDataTrncType,
//   dataMemRDataExtType, ALUControl                static decode
//   Bbranch, Jbranch, JIbranch                     branch-type strobes
//   illegal_instr, mem_fault                       one-cycle fault pulses
//   state                                          current FSM state
//   instret                                        retired-instruction count
module multicycle_control_unit #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             dmem_ready,
  output logic             ir_en,
  output logic             pc_en,
  output logic             regFile_wr_en,
  output logic             dataMem_wr_en,
  output logic             dataMem_rd_req,
  output logic             AluSrcMuxSel,
  output logic [1:0]       RFWriteDataSrcMuxSel,
  output logic [2:0]       immExtType,
  output logic [1:0]       dataMemWDataTrncType,
  output logic [2:0]       dataMemRDataExtType,
  output logic             Bbranch,
  output logic             Jbranch,
  output logic             JIbranch,
  output logic [3:0]       ALUControl,
  output logic             illegal_instr,
  output logic             mem_fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WW = $clog2(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_BAD, C_R, C_IL, C_I, C_S, C_B, C_U, C_UA, C_J, C_JI
  } iclass_t;

  state_t           r_state;
  logic [WW-1:0]    r_wait;
  logic [CNT_W-1:0] r_instret;
  iclass_t          w_class;
  logic             w_mem_ok;
  logic             w_tmo;
  logic             w_retire;
  logic             w_unused;

  // Only funct7[5] carries meaning for RV32I base decode.
  assign w_unused = ^{funct7[6], funct7[4:0]};

  always_comb begin
    case (op)
      7'b0110011: w_class = C_R;
      7'b0000011: w_class = C_IL;
      7'b0010011: w_class = C_I;
      7'b0100011: w_class = C_S;
      7'b1100011: w_class = C_B;
      7'b0110111: w_class = C_U;
      7'b0010111: w_class = C_UA;
      7'b1101111: w_class = C_J;
      7'b1100111: w_class = C_JI;
      default:    w_class = C_BAD;
    endcase
  end

  // Static datapath decode, independent of state.
  always_comb begin
    AluSrcMuxSel         = 1'b0;
    RFWriteDataSrcMuxSel = 2'b00;
    immExtType           = 3'b000;
    dataMemWDataTrncType = 2'b00;
    dataMemRDataExtType  = 3'b000;
    ALUControl           = 4'b0000;
    case (w_class)
      C_R:  ALUControl = {funct7[5], funct3};
      C_I: begin
        immExtType = 3'b001;
        AluSrcMuxSel = 1'b1;
        // Only the shifts use funct7[5] to select arithmetic/logical.
        ALUControl = (funct3 == 3'b001 || funct3 == 3'b101) ?
                     {funct7[5], funct3} : {1'b0, funct3};
      end
      C_IL: begin
        AluSrcMuxSel         = 1'b1;
        RFWriteDataSrcMuxSel = 2'b01;
        dataMemRDataExtType  = funct3;
      end
      C_S: begin
        AluSrcMuxSel         = 1'b1;
        immExtType           = 3'b010;
        dataMemWDataTrncType = funct3[1:0];
      end
      C_B: begin
        immExtType = 3'b011;
        ALUControl = {1'b0, funct3};
      end
      C_U: begin
        RFWriteDataSrcMuxSel = 2'b10;
        immExtType           = 3'b100;
      end
      C_UA: begin
        RFWriteDataSrcMuxSel = 2'b11;
        immExtType           = 3'b100;
      end
      C_J: begin
        RFWriteDataSrcMuxSel = 2'b11;
        immExtType           = 3'b101;
      end
      C_JI: begin
        AluSrcMuxSel         = 1'b1;
        RFWriteDataSrcMuxSel = 2'b11;
        ALUControl           = {1'b0, funct3};
      end
      default: ;
    endcase
  end

  // MEM completion and abort. A ready on the timeout cycle wins.
  assign w_mem_ok = !MEM_HANDSHAKE || dmem_ready;
  assign w_tmo    = MEM_HANDSHAKE && !dmem_ready &&
                    (r_wait == WW'(MEM_TIMEOUT - 1));

  // Strobes decode from the registered state plus the same-cycle
  // dmem_ready, so they follow reset asynchronously through r_state.
  always_comb begin
    ir_en          = 1'b0;
    pc_en          = 1'b0;
    regFile_wr_en  = 1'b0;
    dataMem_wr_en  = 1'b0;
    dataMem_rd_req = 1'b0;
    Bbranch        = 1'b0;
    Jbranch        = 1'b0;
    JIbranch       = 1'b0;
    illegal_instr  = 1'b0;
    mem_fault      = 1'b0;
    case (r_state)
      ST_FETCH: ir_en = 1'b1;
      ST_DECODE: begin
        if (w_class == C_BAD) begin
          illegal_instr = 1'b1;
          pc_en         = 1'b1;
        end
      end
      ST_EXECUTE: begin
        case (w_class)
          C_R, C_I, C_U, C_UA, C_J, C_JI: begin
            regFile_wr_en = 1'b1;
            pc_en         = 1'b1;
          end
          C_B: begin
            Bbranch = 1'b1;
            pc_en   = 1'b1;
          end
          default: ;
        endcase
        Jbranch  = (w_class == C_J) || (w_class == C_JI);
        JIbranch = (w_class == C_JI);
      end
      ST_MEM: begin
        dataMem_wr_en  = (w_class == C_S);
        dataMem_rd_req = (w_class == C_IL);
        if (w_tmo) begin
          mem_fault = 1'b1;
          pc_en     = 1'b1;
        end else if (w_mem_ok && w_class == C_S) begin
          pc_en = 1'b1;
        end
      end
      ST_WB: begin
        regFile_wr_en = 1'b1;
        pc_en         = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_retire = pc_en && !illegal_instr && !mem_fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_INIT;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      if (w_retire) r_instret <= r_instret + 1'b1;
      case (r_state)
        ST_INIT:  r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          r_state <= (w_class == C_BAD) ? ST_FETCH : ST_EXECUTE;
          r_wait  <= '0;
        end
        ST_EXECUTE: begin
          r_state <= (w_class == C_S || w_class == C_IL) ? ST_MEM : ST_FETCH;
          r_wait  <= '0;
        end
        ST_MEM: begin
          if (w_tmo)         r_state <= ST_FETCH;
          else if (w_mem_ok) r_state <= (w_class == C_IL) ? ST_WB : ST_FETCH;
          else               r_wait  <= r_wait + 1'b1;
        end
        ST_WB:   r_state <= ST_FETCH;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        dmem_ready;
  logic        ir_en, pc_en, regFile_wr_en, dataMem_wr_en, dataMem_rd_req;
  logic        AluSrcMuxSel;
  logic [1:0]  RFWriteDataSrcMuxSel;
  logic [2:0]  immExtType;
  logic [1:0]  dataMemWDataTrncType;
  logic [2:0]  dataMemRDataExtType;
  logic        Bbranch, Jbranch, JIbranch;
  logic [3:0]  ALUControl;
  logic        illegal_instr, mem_fault;
  logic [2:0]  state;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;

  multicycle_control_unit #(
    .MEM_HANDSHAKE(1'b1),
    .MEM_TIMEOUT(16),
    .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .dmem_ready(dmem_ready), .ir_en(ir_en), .pc_en(pc_en),
    .regFile_wr_en(regFile_wr_en), .dataMem_wr_en(dataMem_wr_en),
    .dataMem_rd_req(dataMem_rd_req), .AluSrcMuxSel(AluSrcMuxSel),
    .RFWriteDataSrcMuxSel(RFWriteDataSrcMuxSel), .immExtType(immExtType),
    .dataMemWDataTrncType(dataMemWDataTrncType),
    .dataMemRDataExtType(dataMemRDataExtType), .Bbranch(Bbranch),
    .Jbranch(Jbranch), .JIbranch(JIbranch), .ALUControl(ALUControl),
    .illegal_instr(illegal_instr), .mem_fault(mem_fault), .state(state),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
    dmem_ready = 1'b0;
    tick(); tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++; if ({ir_en, pc_en, regFile_wr_en, dataMem_wr_en, dataMem_rd_req} !== 5'b0)
      begin errors++; $display("FAIL reset_strobes got=%b exp=00000", {ir_en, pc_en, regFile_wr_en, dataMem_wr_en, dataMem_rd_req}); end
  endtask

  // Releases reset, runs one add: INIT, FETCH, DECODE, EXECUTE, FETCH.
  task automatic test_add();
    logic [2:0] exp_st [3] = '{3'd1, 3'd2, 3'd3};
    reset = 1'b1;
    checks++; if (state !== 3'd0 || ir_en !== 1'b0) begin errors++; $display("FAIL add_init got state=%0d ir_en=%b exp 0/0", state, ir_en); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (state !== exp_st[c]) begin errors++; $display("FAIL add_state[%0d] got=%0d exp=%0d", c, state, exp_st[c]); end
      checks++; if (pc_en !== (c == 2) || regFile_wr_en !== (c == 2))
        begin errors++; $display("FAIL add_strobes[%0d] got pc=%b wr=%b exp=%b", c, pc_en, regFile_wr_en, c == 2); end
    end
    checks++; if (ir_en !== 1'b0) begin errors++; $display("FAIL add_ir_en_exec got=%b exp=0", ir_en); end
    tick();
    checks++; if (state !== 3'd1 || ir_en !== 1'b1) begin errors++; $display("FAIL add_refetch got state=%0d ir_en=%b exp 1/1", state, ir_en); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL add_instret got=%0d exp=1", instret); end
  endtask

  // lw, memory ready on the third MEM cycle: 7 cycles total.
  task automatic test_load();
    logic [2:0] exp_st [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5};
    int rd_cnt = 0;
    op = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0000000; dmem_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      dmem_ready = (c == 5);
      #1;
      if (dataMem_rd_req === 1'b1) rd_cnt++;
      checks++; if (state !== exp_st[c]) begin errors++; $display("FAIL load_state[%0d] got=%0d exp=%0d", c, state, exp_st[c]); end
      checks++; if (pc_en !== (c == 6) || regFile_wr_en !== (c == 6))
        begin errors++; $display("FAIL load_strobes[%0d] got pc=%b wr=%b exp=%b", c, pc_en, regFile_wr_en, c == 6); end
    end
    checks++; if (rd_cnt != 3) begin errors++; $display("FAIL load_rd_req_cycles got=%0d exp=3", rd_cnt); end
    checks++; if (dataMemRDataExtType !== 3'b010 || RFWriteDataSrcMuxSel !== 2'b01)
      begin errors++; $display("FAIL load_decode got ext=%b rfsel=%b exp 010/01", dataMemRDataExtType, RFWriteDataSrcMuxSel); end
    tick();
    dmem_ready = 1'b0;
    checks++; if (state !== 3'd1 || instret !== 32'd2) begin errors++; $display("FAIL load_end got state=%0d instret=%0d exp 1/2", state, instret); end
  endtask

  // sh with memory never ready: abort on the 16th MEM cycle.
  task automatic test_store_timeout();
    int fault_at = -1;
    int wr_cnt = 0;
    op = 7'b0100011; funct3 = 3'b001; dmem_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL st_enter_mem got=%0d exp=4", state); end
    checks++; if (dataMemWDataTrncType !== 2'b01 || immExtType !== 3'b010)
      begin errors++; $display("FAIL st_decode got trnc=%b imm=%b exp 01/010", dataMemWDataTrncType, immExtType); end
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick();
      if (dataMem_wr_en === 1'b1) wr_cnt++;
      if (mem_fault === 1'b1) fault_at = k;
      checks++; if (pc_en !== (k == 16)) begin errors++; $display("FAIL st_pc_en[%0d] got=%b exp=%b", k, pc_en, k == 16); end
    end
    checks++; if (fault_at != 16) begin errors++; $display("FAIL st_fault_cycle got=%0d exp=16", fault_at); end
    checks++; if (wr_cnt != 16) begin errors++; $display("FAIL st_wr_cycles got=%0d exp=16", wr_cnt); end
    tick();
    checks++; if (state !== 3'd1 || dataMem_wr_en !== 1'b0 || mem_fault !== 1'b0)
      begin errors++; $display("FAIL st_after got state=%0d wr=%b fault=%b exp 1/0/0", state, dataMem_wr_en, mem_fault); end
    checks++; if (instret !== 32'd2) begin errors++; $display("FAIL st_instret got=%0d exp=2", instret); end
  endtask

  task automatic test_illegal();
    op = 7'b1111111; funct3 = 3'b111; funct7 = 7'b0100000;
    #1;
    checks++; if ({AluSrcMuxSel, RFWriteDataSrcMuxSel, immExtType, ALUControl} !== 10'b0)
      begin errors++; $display("FAIL ill_decode got=%b exp=0", {AluSrcMuxSel, RFWriteDataSrcMuxSel, immExtType, ALUControl}); end
    tick();
    checks++; if (state !== 3'd2 || illegal_instr !== 1'b1 || pc_en !== 1'b1)
      begin errors++; $display("FAIL ill_decode_cycle got state=%0d ill=%b pc=%b exp 2/1/1", state, illegal_instr, pc_en); end
    tick();
    checks++; if (state !== 3'd1 || illegal_instr !== 1'b0) begin errors++; $display("FAIL ill_back got state=%0d ill=%b exp 1/0", state, illegal_instr); end
    checks++; if (instret !== 32'd2) begin errors++; $display("FAIL ill_instret got=%0d exp=2", instret); end
  endtask

  task automatic test_alu_imm();
    op = 7'b0010011; funct3 = 3'b101; funct7 = 7'b0100000; #1;
    checks++; if (ALUControl !== 4'b1101) begin errors++; $display("FAIL alu_srai got=%b exp=1101", ALUControl); end
    checks++; if (AluSrcMuxSel !== 1'b1 || immExtType !== 3'b001) begin errors++; $display("FAIL alu_i_src got src=%b imm=%b exp 1/001", AluSrcMuxSel, immExtType); end
    funct3 = 3'b000; #1;
    checks++; if (ALUControl !== 4'b0000) begin errors++; $display("FAIL alu_addi got=%b exp=0000", ALUControl); end
    tick(); tick();
    checks++; if (state !== 3'd3 || regFile_wr_en !== 1'b1 || pc_en !== 1'b1)
      begin errors++; $display("FAIL alu_exec got state=%0d wr=%b pc=%b exp 3/1/1", state, regFile_wr_en, pc_en); end
    tick();
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL alu_instret got=%0d exp=3", instret); end
  endtask

  // B then JI back to back; EXECUTE strobes {B,J,JI,wr}.
  task automatic test_back_to_back();
    logic [6:0] ops  [2] = '{7'b1100011, 7'b1100111};
    logic [3:0] expb [2] = '{4'b1000, 4'b0111};
    logic [3:0] expa [2] = '{4'b0001, 4'b0001};
    for (int i = 0; i < 2; i++) begin
      op = ops[i]; funct3 = 3'b001; funct7 = 7'b0000000;
      tick(); tick();
      checks++; if ({Bbranch, Jbranch, JIbranch, regFile_wr_en} !== expb[i] || pc_en !== 1'b1)
        begin errors++; $display("FAIL b2b_strobes[%0d] got=%b pc=%b exp=%b pc=1", i, {Bbranch, Jbranch, JIbranch, regFile_wr_en}, pc_en, expb[i]); end
      checks++; if (ALUControl !== expa[i]) begin errors++; $display("FAIL b2b_alu[%0d] got=%b exp=%b", i, ALUControl, expa[i]); end
      tick();
      checks++; if ({Bbranch, Jbranch, JIbranch} !== 3'b000 || state !== 3'd1)
        begin errors++; $display("FAIL b2b_after[%0d] got br=%b state=%0d exp 000/1", i, {Bbranch, Jbranch, JIbranch}, state); end
    end
    checks++; if (instret !== 32'd5) begin errors++; $display("FAIL b2b_instret got=%0d exp=5", instret); end
  endtask

  task automatic test_reset_mid_store();
    op = 7'b0100011; funct3 = 3'b000; dmem_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (state !== 3'd4 || dataMem_wr_en !== 1'b1) begin errors++; $display("FAIL rst_pre got state=%0d wr=%b exp 4/1", state, dataMem_wr_en); end
    #2 reset = 1'b0;
    #1;
    checks++; if (dataMem_wr_en !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL rst_async_wr got wr=%b pc=%b exp 0/0", dataMem_wr_en, pc_en); end
    checks++; if (state !== 3'd0 || instret !== 32'd0) begin errors++; $display("FAIL rst_async_state got state=%0d instret=%0d exp 0/0", state, instret); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL rst_refetch got=%0d exp=1", state); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store_timeout();
    test_illegal();
    test_alu_imm();
    test_back_to_back();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle successor to the single-cycle RV32I control decoder. It sequences each instruction through INIT/FETCH/DECODE/EXECUTE/MEM/WB states and gates all write and branch strobes by state. It waits on a data-memory ready handshake, with a parametrised timeout and an optional fixed-latency mode. It also flags illegal opcodes and counts retired instructions. It sits between the instruction register and the datapath (PC, register file, ALU, data memory interface).

## Interface
- MEM_HANDSHAKE, 1, 1: MEM waits for dmem_ready; 0: MEM always lasts exactly one cycle
- MEM_TIMEOUT, 16, max MEM cycles without dmem_ready before abort (≥2)
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- op  in  7  opcode from instruction register
- funct3  in  3  from instruction register
- funct7  in  7  from instruction register
- dmem_ready  in  1  data memory completes current access this cycle
- ir_en  out  1  load instruction register
- pc_en  out  1  update PC (next-PC mux driven by branch strobes)
- regFile_wr_en  out  1  register file write strobe
- dataMem_wr_en  out  1  store strobe
- dataMem_rd_req  out  1  load request
- AluSrcMuxSel  out  1  0=rs2, 1=imm
- RFWriteDataSrcMuxSel  out  2  00 ALU, 01 load data, 10 imm, 11 PC-based
- immExtType  out  3  immediate format
- dataMemWDataTrncType  out  2  store size
- dataMemRDataExtType  out  3  load size/sign
- Bbranch, Jbranch, JIbranch  out  1 each  branch-type strobes
- ALUControl  out  4  ALU operation
- illegal_instr  out  1  one-cycle pulse on unknown opcode
- mem_fault  out  1  one-cycle pulse on MEM timeout
- state  out  3  INIT=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5
- instret  out  CNT_W  retired-instruction count

## Operation
- Opcodes:
  - R 0110011
  - IL 0000011
  - I 0010011
  - S 0100011
  - B 1100011
  - U 0110111
  - UA 0010111
  - J 1101111
  - JI 1100111
- Static decode is combinational from op/funct3/funct7 in all states. Unknown opcodes drive all of these to 0.
  - AluSrcMuxSel=1 for IL, I, S, JI; otherwise 0.
  - RFWriteDataSrcMuxSel: R/I 00; IL 01; U 10; UA/J/JI 11.
  - immExtType: IL/JI/R 000; I 001; S 010; B 011; U/UA 100; J 101.
  - dataMemWDataTrncType=funct3[1:0] for S, else 00. dataMemRDataExtType=funct3 for IL, else 000.
  - ALUControl:
    - R: {funct7[5],funct3}
    - I: {funct7[5],funct3} when funct3 is 001/101, else {0,funct3}
    - IL/S/U/UA/J: 0000
    - B/JI: {0,funct3}
- FSM:
  - INIT→FETCH.
  - FETCH (ir_en=1)→DECODE.
  - DECODE→EXECUTE for legal opcodes.
  - DECODE on illegal opcode: illegal_instr=1, pc_en=1, →FETCH. instret is not incremented.
  - EXECUTE for R/I/U/UA/J/JI: regFile_wr_en=1, pc_en=1, →FETCH.
  - EXECUTE for B: Bbranch=1, pc_en=1, →FETCH.
  - EXECUTE for S/IL: →MEM.
  - MEM for S: dataMem_wr_en=1 while in MEM. On exit, pc_en=1 and →FETCH.
  - MEM for IL: dataMem_rd_req=1 while in MEM. On exit, →WB.
  - WB (IL only): regFile_wr_en=1, pc_en=1, →FETCH.
  - Jbranch=1 in EXECUTE for J and JI. JIbranch=1 in EXECUTE for JI only.
- MEM exit rules:
  - MEM_HANDSHAKE=0: exit after one cycle.
  - MEM_HANDSHAKE=1: exit in the cycle dmem_ready=1.
  - Timeout: a wait counter clears on MEM entry and counts cycles in MEM. If it reaches MEM_TIMEOUT-1 with dmem_ready=0: mem_fault=1, pc_en=1, no register write, →FETCH.
  - dmem_ready=1 on the timeout cycle counts as success.
- instret increments by 1, with wrap-around at 2^CNT_W, in every cycle where pc_en=1 and neither illegal_instr nor mem_fault is asserted.
- All strobes not listed for a state are 0.

## Timing
- Reset: state=INIT; instret=0; wait counter=0. All strobes (ir_en, pc_en, write/req strobes, branch strobes, illegal_instr, mem_fault) are 0 in INIT and while reset is held.
- Reset asserted mid-instruction aborts immediately: no strobe in flight survives.
- First FETCH occurs one cycle after reset deassertion.
- Instruction latency in cycles:
  - R/I/U/UA/B/J/JI: 3
  - S: 4+waits
  - IL: 5+waits
  - illegal: 2
- pc_en is asserted for exactly one cycle per instruction.
- dmem_ready is sampled only in MEM and ignored elsewhere.

## Test plan
- Release reset, op=0110011 (add) → state 0,1,2,3,1; regFile_wr_en and pc_en high only in cycle 3; instret=1.
- op=0000011, funct3=010, MEM_HANDSHAKE=1, dmem_ready high after 3 MEM cycles → dataMem_rd_req high 3 cycles; WB writes; total 7 cycles; dataMemRDataExtType=010.
- op=0100011, funct3=001, dmem_ready never high, MEM_TIMEOUT=16 → mem_fault pulse on the 16th MEM cycle; no dataMem_wr_en after exit; instret unchanged.
- op=1111111 → illegal_instr pulse in DECODE; pc_en same cycle; back to FETCH; instret unchanged.
- op=0010011, funct3=101, funct7=0100000 → ALUControl=1101; funct3=000, funct7=0100000 → ALUControl=0000.
- Assert reset during MEM of a store → dataMem_wr_en drops to 0 asynchronously; state=0; instret=0.
